ifid_queue: RTL

IFID_QUEUE -- requirements
Module: ifid_queue

---
 rtl/ifid_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/ifid_queue.sv
// IF/ID decoupling queue: a small circular buffer of fetched {pc, instr, fault}
// entries between the fetch and decode stages. A flush discards everything.
// The ready/valid outputs come only from registered occupancy, so there is no
// combinational path from input to output.
module ifid_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            in_fault,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_fault,
  output logic [CNTW-1:0] count
);

  localparam int unsigned PTRW     = $clog2(DEPTH);
  localparam logic [31:0] NopInstr = 32'h00000013;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            fault_mem [DEPTH];

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push, pop;

  // Handshakes: flush suppresses both push and pop.
  always_comb begin
    in_ready  = (count_q != CNTW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Next-state for pointers and occupancy; DEPTH is a power of two, so the
  // pointers wrap modulo DEPTH by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      if (push && !pop)      count_d = count_q + CNTW'(1);
      else if (pop && !push) count_d = count_q - CNTW'(1);
    end
  end

  // Pointer and occupancy state with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful when counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
      fault_mem[wr_ptr_q] <= in_fault;
    end
  end

  // Head outputs; an empty queue presents a NOP so ID never sees stale data.
  always_comb begin
    out_pc    = '0;
    out_instr = NopInstr;
    out_fault = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
      out_fault = fault_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule
